// File: rtl/sim_host_responder_if.sv
// rtl/sim_host_responder_if.sv - host request/response bus for sim_host_responder
// The responder binds the slave modport; the host side binds master.
interface sim_host_responder_if;
  logic        o_master_ready;
  logic        i_ih_reset;
  logic        i_ih_ready;
  logic [31:0] i_in_command;
  logic [31:0] i_in_address;
  logic [31:0] i_in_data;
  logic [27:0] i_in_data_count;
  logic        i_oh_ready;
  logic        o_oh_en;
  logic [31:0] o_out_status;
  logic [31:0] o_out_address;
  logic [31:0] o_out_data;
  logic [27:0] o_out_data_count;

  modport slave (
    output o_master_ready,
    input  i_ih_reset,
    input  i_ih_ready,
    input  i_in_command,
    input  i_in_address,
    input  i_in_data,
    input  i_in_data_count,
    input  i_oh_ready,
    output o_oh_en,
    output o_out_status,
    output o_out_address,
    output o_out_data,
    output o_out_data_count
  );

  modport master (
    input  o_master_ready,
    output i_ih_reset,
    output i_ih_ready,
    output i_in_command,
    output i_in_address,
    output i_in_data,
    output i_in_data_count,
    output i_oh_ready,
    input  o_oh_en,
    input  o_out_status,
    input  o_out_address,
    input  o_out_data,
    input  o_out_data_count
  );
endinterface

// File: rtl/sim_host_responder.sv
// rtl/sim_host_responder.sv - simulated host responder: ping, multi-word write and read on a small word memory
// Commands arrive as single-cycle strobes; every response word is a registered single-cycle pulse.
module sim_host_responder #(
  parameter int MEM_ADDR_BITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  sim_host_responder_if.slave host
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [3:0] OP_PING  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_DATA,
    READ_DATA,
    SEND_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] start_addr_q, start_addr_d;
  logic [27:0] remaining_q, remaining_d;
  logic        master_ready_q, master_ready_d;
  logic        oh_en_q, oh_en_d;
  logic [31:0] out_status_q, out_status_d;
  logic [31:0] out_address_q, out_address_d;
  logic [31:0] out_data_q, out_data_d;
  logic [27:0] out_count_q, out_count_d;

  logic [31:0] mem_q [MEM_DEPTH];
  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_waddr;
  logic [31:0]              mem_wdata;

  logic [27:0] count_eff;
  logic [27:0] rem_dec;

  assign count_eff = (host.i_in_data_count == 28'd0) ? 28'd1 : host.i_in_data_count;
  assign rem_dec   = remaining_q - 28'd1;

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    addr_d        = addr_q;
    start_addr_d  = start_addr_q;
    remaining_d   = remaining_q;
    oh_en_d       = 1'b0;
    out_status_d  = out_status_q;
    out_address_d = out_address_q;
    out_data_d    = out_data_q;
    out_count_d   = out_count_q;
    mem_we        = 1'b0;
    mem_waddr     = addr_q[MEM_ADDR_BITS-1:0];
    mem_wdata     = host.i_in_data;

    // Soft reset wins over everything, including a word strobed in the same cycle.
    if (host.i_ih_reset) begin
      state_d       = IDLE;
      remaining_d   = 28'd0;
      out_status_d  = 32'd0;
      out_address_d = 32'd0;
      out_data_d    = 32'd0;
      out_count_d   = 28'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.i_ih_ready) begin
            start_addr_d = host.i_in_address;
            addr_d       = host.i_in_address;
            remaining_d  = count_eff;
            status_d     = ~host.i_in_command;
            case (host.i_in_command[3:0])
              OP_PING: state_d = SEND_RESP;
              OP_WRITE: begin
                mem_we      = 1'b1;
                mem_waddr   = host.i_in_address[MEM_ADDR_BITS-1:0];
                addr_d      = host.i_in_address + 32'd1;
                remaining_d = count_eff - 28'd1;
                state_d     = (count_eff == 28'd1) ? SEND_RESP : WRITE_DATA;
              end
              OP_READ: state_d = READ_DATA;
              default: begin
                status_d = 32'hFFFF_FFFF;
                state_d  = SEND_RESP;
              end
            endcase
          end
        end

        WRITE_DATA: begin
          if (host.i_ih_ready) begin
            mem_we      = 1'b1;
            addr_d      = addr_q + 32'd1;
            remaining_d = rem_dec;
            if (rem_dec == 28'd0) state_d = SEND_RESP;
          end
        end

        READ_DATA: begin
          // The !oh_en_q term leaves at least one idle cycle between read words.
          if (host.i_oh_ready && !oh_en_q) begin
            oh_en_d       = 1'b1;
            out_status_d  = status_q;
            out_address_d = addr_q;
            out_data_d    = mem_q[addr_q[MEM_ADDR_BITS-1:0]];
            out_count_d   = rem_dec;
            addr_d        = addr_q + 32'd1;
            remaining_d   = rem_dec;
            if (rem_dec == 28'd0) state_d = IDLE;
          end
        end

        SEND_RESP: begin
          if (host.i_oh_ready) begin
            oh_en_d       = 1'b1;
            out_status_d  = status_q;
            out_address_d = start_addr_q;
            out_data_d    = 32'd0;
            out_count_d   = 28'd0;
            state_d       = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    master_ready_d = (state_d == IDLE) || (state_d == WRITE_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      status_q       <= 32'd0;
      addr_q         <= 32'd0;
      start_addr_q   <= 32'd0;
      remaining_q    <= 28'd0;
      master_ready_q <= 1'b0;
      oh_en_q        <= 1'b0;
      out_status_q   <= 32'd0;
      out_address_q  <= 32'd0;
      out_data_q     <= 32'd0;
      out_count_q    <= 28'd0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      addr_q         <= addr_d;
      start_addr_q   <= start_addr_d;
      remaining_q    <= remaining_d;
      master_ready_q <= master_ready_d;
      oh_en_q        <= oh_en_d;
      out_status_q   <= out_status_d;
      out_address_q  <= out_address_d;
      out_data_q     <= out_data_d;
      out_count_q    <= out_count_d;
    end
  end

  // Memory survives both resets, so it sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign host.o_master_ready   = master_ready_q;
  assign host.o_oh_en          = oh_en_q;
  assign host.o_out_status     = out_status_q;
  assign host.o_out_address    = out_address_q;
  assign host.o_out_data       = out_data_q;
  assign host.o_out_data_count = out_count_q;

endmodule

// File: tb/tb_sim_host_responder.sv
// tb/tb_sim_host_responder.sv - randomized self-checking bench for sim_host_responder
// Transactions are scored against a word-array model of the memory and response rules.
module tb_sim_host_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sim_host_responder_if bus();

  sim_host_responder #(.MEM_ADDR_BITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus)
  );

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] addr;
    logic [31:0] data;
    logic [27:0] cnt;
  } rsp_t;

  rsp_t        got_q[$];
  rsp_t        exp_q[$];
  rsp_t        last_rsp;
  logic [31:0] mem_m [16];
  logic [31:0] wbuf [32];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        prev_ready = 1'b0;
  logic        prev_en = 1'b0;
  bit          rand_rdy = 1'b0;
  logic        rdy_force = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) prev_ready <= bus.i_oh_ready;

  always @(negedge clk) begin
    rsp_t r;
    if (!rst && bus.o_oh_en) begin
      check_eq("en_without_ready", 64'(prev_ready), 64'd1);
      check_eq("en_back_to_back", 64'(prev_en), 64'd0);
      r.status = bus.o_out_status;
      r.addr   = bus.o_out_address;
      r.data   = bus.o_out_data;
      r.cnt    = bus.o_out_data_count;
      got_q.push_back(r);
    end
    prev_en = bus.o_oh_en;
  end

  initial begin
    bus.i_oh_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_oh_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_txn(input logic [31:0] cmd, input logic [31:0] addr, input logic [27:0] cnt);
    int          n;
    rsp_t        r;
    logic [31:0] a;
    n = (cnt == 28'd0) ? 1 : int'(cnt);
    exp_q.delete();
    case (cmd[3:0])
      4'd0: begin
        r = '{~cmd, addr, 32'd0, 28'd0};
        exp_q.push_back(r);
      end
      4'd1: begin
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          mem_m[a[3:0]] = wbuf[i];
        end
        r = '{~cmd, addr, 32'd0, 28'd0};
        exp_q.push_back(r);
      end
      4'd2: begin
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          r = '{~cmd, a, mem_m[a[3:0]], 28'(n - 1 - i)};
          exp_q.push_back(r);
        end
      end
      default: begin
        r = '{32'hFFFF_FFFF, addr, 32'd0, 28'd0};
        exp_q.push_back(r);
      end
    endcase
  endtask

  task automatic send_word(input logic [31:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [27:0] cnt);
    int t = 0;
    while (!bus.o_master_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("master_ready_wait", 64'(bus.o_master_ready), 64'd1);
    bus.i_in_command    = cmd;
    bus.i_in_address    = addr;
    bus.i_in_data       = data;
    bus.i_in_data_count = cnt;
    bus.i_ih_ready      = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ih_ready      = 1'b0;
  endtask

  task automatic drive_txn(input logic [31:0] cmd, input logic [31:0] addr, input logic [27:0] cnt);
    int n;
    n = (cnt == 28'd0) ? 1 : int'(cnt);
    send_word(cmd, addr, wbuf[0], cnt);
    if (cmd[3:0] == 4'd1)
      for (int i = 1; i < n; i++) send_word($urandom, $urandom, wbuf[i], 28'($urandom));
  endtask

  task automatic collect();
    int   t = 0;
    rsp_t g;
    rsp_t e;
    while (got_q.size() < exp_q.size() && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("rsp_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check_eq("rsp_status", 64'(g.status), 64'(e.status));
      check_eq("rsp_address", 64'(g.addr), 64'(e.addr));
      check_eq("rsp_data", 64'(g.data), 64'(e.data));
      check_eq("rsp_count_field", 64'(g.cnt), 64'(e.cnt));
      last_rsp = g;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic run_txn(input logic [31:0] cmd, input logic [31:0] addr, input logic [27:0] cnt);
    model_txn(cmd, addr, cnt);
    drive_txn(cmd, addr, cnt);
    collect();
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] sv_a;
    logic [31:0] sv_b;
    logic [31:0] sv_c;
    logic [3:0]  ops [6];
    int          t;

    ops = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd7};
    bus.i_ih_reset      = 1'b0;
    bus.i_ih_ready      = 1'b0;
    bus.i_in_command    = 32'd0;
    bus.i_in_address    = 32'd0;
    bus.i_in_data       = 32'd0;
    bus.i_in_data_count = 28'd0;

    #1;
    check_eq("rst_master_ready", 64'(bus.o_master_ready), 64'd0);
    check_eq("rst_oh_en", 64'(bus.o_oh_en), 64'd0);
    check_eq("rst_status", 64'(bus.o_out_status), 64'd0);
    check_eq("rst_count", 64'(bus.o_out_data_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", 64'(bus.o_master_ready), 64'd1);

    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    run_txn(32'h1, 32'h0, 28'd16);

    run_txn(32'h0, 32'h10, 28'd0);
    check_eq("ping_status", 64'(last_rsp.status), 64'hFFFF_FFFF);
    check_eq("ping_address", 64'(last_rsp.addr), 64'h10);

    sv_a = $urandom; sv_b = $urandom; sv_c = $urandom;
    wbuf[0] = sv_a; wbuf[1] = sv_b; wbuf[2] = sv_c;
    run_txn(32'h1, 32'h2, 28'd3);
    check_eq("write_status", 64'(last_rsp.status), 64'hFFFF_FFFE);
    run_txn(32'h2, 32'h2, 28'd3);
    check_eq("read_last_data", 64'(last_rsp.data), 64'(sv_c));
    check_eq("read_last_addr", 64'(last_rsp.addr), 64'h4);

    sv_a = $urandom; sv_b = $urandom;
    wbuf[0] = sv_a; wbuf[1] = sv_b;
    run_txn(32'h1, 32'hF, 28'd2);
    check_eq("wrap_write_addr", 64'(last_rsp.addr), 64'hF);
    run_txn(32'h2, 32'h0, 28'd1);
    check_eq("wrap_read_data", 64'(last_rsp.data), 64'(sv_b));

    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    model_txn(32'h2, 32'h5, 28'd2);
    drive_txn(32'h2, 32'h5, 28'd2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_eq("backpressure_no_pulse", 64'(got_q.size()), 64'd0);
    rdy_force = 1'b1;
    collect();

    wbuf[0] = $urandom; wbuf[1] = $urandom;
    mem_m[8] = wbuf[0];
    mem_m[9] = wbuf[1];
    send_word(32'h1, 32'h8, wbuf[0], 28'd4);
    send_word($urandom, $urandom, wbuf[1], 28'd0);
    bus.i_ih_reset = 1'b1;
    bus.i_ih_ready = 1'b1;
    bus.i_in_data  = $urandom;
    @(posedge clk);
    #1;
    bus.i_ih_reset = 1'b0;
    bus.i_ih_ready = 1'b0;
    check_eq("srst_master_ready", 64'(bus.o_master_ready), 64'd1);
    check_eq("srst_status", 64'(bus.o_out_status), 64'd0);
    check_eq("srst_address", 64'(bus.o_out_address), 64'd0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check_eq("srst_no_response", 64'(got_q.size()), 64'd0);
    run_txn(32'h2, 32'h8, 28'd3);

    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      c = $urandom;
      c[3:0] = ops[$urandom_range(0, 5)];
      a = (k % 4 == 0) ? $urandom : 32'($urandom_range(0, 31));
      for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
      run_txn(c, a, 28'($urandom_range(0, 5)));
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;

    model_txn(32'h2, 32'h0, 28'd4);
    drive_txn(32'h2, 32'h0, 28'd4);
    t = 0;
    while (got_q.size() < 1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("areset_first_pulse", 64'(got_q.size() >= 1), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("areset_oh_en", 64'(bus.o_oh_en), 64'd0);
    check_eq("areset_status", 64'(bus.o_out_status), 64'd0);
    check_eq("areset_address", 64'(bus.o_out_address), 64'd0);
    check_eq("areset_data", 64'(bus.o_out_data), 64'd0);
    check_eq("areset_count", 64'(bus.o_out_data_count), 64'd0);
    check_eq("areset_master_ready", 64'(bus.o_master_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    @(posedge clk);
    #1;
    check_eq("ready_after_areset", 64'(bus.o_master_ready), 64'd1);
    run_txn(32'h2, 32'h0, 28'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
